lsu_mem_port: RTL
=================

// Module: lsu_mem_port
// PURPOSE
//  Load/store initiator between the EX/MEM pipeline stage and the byte-addressed, big-endian data memory.
//  Accepts one request at a time and decodes the op. Drives the memory's address, write data and write-type code.
//  For loads, captures the registered read word and performs lane select plus sign/zero extension.
//  Maintains a single LL/SC reservation. Checks alignment. Returns one response per accepted request.
// PARAMETERS
//  AW  16  memory byte-address width (wraps modulo 2**AW)
//  DW  32  data width; fixed at 32 (lane logic assumes 4 bytes)
// PORTS
//  Clk          in   1   clock; all state updates on posedge
//  Reset        in   1   synchronous, active-high reset
//  req_valid    in   1   request present
//  req_ready    out  1   high only in IDLE; accept = req_valid & req_ready
//  req_op       in   4   0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 SW, 6 SB, 7 SH, 8 LL, 9 SC; others illegal
//  req_addr     in   AW  byte address
//  req_wdata    in   32  store data (SB uses [7:0], SH uses [15:0])
//  resp_valid   out  1   response held until resp_ready
//  resp_ready   in   1   consumer accepts response
//  resp_rdata   out  32  load result; SC: 1 on success, 0 on failure; stores: 0
//  resp_err     out  1   misaligned or illegal op; no memory access was made
//  mem_addr     out  AW  memory address
//  mem_wdata    out  32  memory write data
//  mem_wr       out  3   0 read, 1 word write, 2 byte write (Ad), 3 SC word write, 4 half write (Ad+2, Ad+3)
//  mem_rdata    in   32  memory read word; registered by memory, valid the cycle after the address is held with mem_wr=0
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_wr=0, mem_addr=0, mem_wdata=0, reservation cleared.
//  FSM: IDLE -> ACCESS -> (load: WAIT) -> RESP -> IDLE. A misaligned or illegal request goes IDLE -> RESP directly.
//  Accepted request (op, addr, wdata) is registered at acceptance cycle T. Pipeline inputs are not used after acceptance.
//  Latency: store/SC resp_valid at T+2; load/LL resp_valid at T+3; error resp_valid at T+1.
//  mem_wr is nonzero only in ACCESS, for exactly 1 cycle per store. In all other states mem_wr=0 and mem_addr holds its last value.
//  Address mapping:
//   - Loads and LL: mem_addr = addr & ~3.
//   - SW and SC: mem_addr = addr.
//   - SB: mem_addr = addr, mem_wdata = {24'd0, wdata[7:0]}.
//   - SH: mem_addr = addr - 2 (mod 2**AW), mem_wdata = {16'd0, wdata[15:0]}.
//  Alignment:
//   - LW, SW, LL and SC require addr[1:0]=0.
//   - LH, LHU and SH require addr[0]=0.
//   - Byte ops never fault.
//  Load extraction in WAIT (big-endian, offset o = addr[1:0]): the byte is mem_rdata[31-8o -: 8]; the half is mem_rdata[31-8o -: 16].
//   - LB/LH sign-extend; LBU/LHU zero-extend.
//   - LW/LL pass the word through.
//   - Extracted value is registered into resp_rdata on WAIT->RESP.
//  LL/SC reservation:
//   - LL sets res_valid=1 and res_addr = addr[AW-1:2].
//   - SC succeeds iff res_valid and res_addr match: mem_wr=3, result 1. On failure, no write (mem_wr=0 in ACCESS), result 0.
//   - Any SC clears res_valid.
//   - Any SW/SB/SH whose word address equals res_addr clears res_valid.
//   - A misaligned LL/SC does not touch the reservation.
//  RESP: resp_valid=1, resp_rdata/resp_err stable until resp_ready.
//   - On resp_ready, the block goes to IDLE; resp_valid drops the next cycle.
//   - Back-to-back: a new request can be accepted the cycle after the handshake.
//  Reset mid-operation: state returns to IDLE on the reset edge and mem_wr=0 from the next cycle. A write coinciding with the reset edge is discarded by the memory.
//  The data memory's cut-select input is tied to 0 in the datapath; all narrowing is done in this block.
// STRUCTURE
//  lsu_pkg holds the op codes and mem_wr codes (MW_READ, MW_WORD, MW_BYTE, MW_SC, MW_HALF) plus the state enum.
//  Sub-module lsu_extract is combinational: (word, offset, op) -> 32-bit extended load result.
//  The top level contains the FSM, request registers, reservation register and response registers.
// TESTING
//  1. SW addr=0x0010 wdata=0xDEADBEEF, then LW 0x0010 -> mem_wr=1 once at T+1; load resp_rdata=0xDEADBEEF at T+3.
//  2. After test 1: LB 0x0013 -> 0xFFFFFFEF; LBU 0x0013 -> 0x000000EF; LH 0x0010 -> 0xFFFFDEAD; LHU 0x0012 -> 0x0000BEEF.
//  3. SH addr=0x0012 wdata=0x1234 -> mem_addr=0x0010, mem_wr=4; a following LW 0x0010 returns 0xDEAD1234.
//  4. Misaligned: LW 0x0011 and SH 0x0003 -> resp_err=1 at T+1; mem_wr stays 0 throughout; the reservation is unchanged.
//  5. LL 0x0020, then SC 0x0020 wdata=5 -> resp_rdata=1, mem_wr=3. A second SC -> resp_rdata=0, no write. LL 0x0020, SB 0x0022, SC 0x0020 -> resp_rdata=0.
//  6. Hold resp_ready=0 for 4 cycles (resp stable, req_ready=0). Assert Reset during ACCESS of an SW -> IDLE next cycle, resp_valid=0, mem_wr=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the LSU memory port: request op codes, memory write-type codes, FSM states.
// Latency: none; this file holds only definitions and pure helper functions.
// Backpressure: none.
package lsu_pkg;

  typedef enum logic [3:0] {
    OP_LW  = 4'd0,
    OP_LB  = 4'd1,
    OP_LBU = 4'd2,
    OP_LH  = 4'd3,
    OP_LHU = 4'd4,
    OP_SW  = 4'd5,
    OP_SB  = 4'd6,
    OP_SH  = 4'd7,
    OP_LL  = 4'd8,
    OP_SC  = 4'd9
  } op_e;

  // Write-type code seen by the data memory; the memory does its own lane placement.
  typedef enum logic [2:0] {
    MW_READ = 3'd0,
    MW_WORD = 3'd1,
    MW_BYTE = 3'd2,
    MW_SC   = 3'd3,
    MW_HALF = 3'd4
  } mw_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic [3:0] OP_LAST = 4'd9;

  // Raw op code check; anything above SC is illegal.
  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_LAST;
  endfunction

  // Ops that read memory and come back through the extraction path.
  function automatic logic op_is_load(input op_e op);
    return op inside {OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LL};
  endfunction

  // Plain stores; these can break a reservation on the same word.
  function automatic logic op_is_store(input op_e op);
    return op inside {OP_SW, OP_SB, OP_SH};
  endfunction

  // Word ops need a 4-byte aligned address, half ops 2-byte, byte ops never fault.
  function automatic logic op_misaligned(input op_e op, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_LL, OP_SC: bad = (lo != 2'b00);
      OP_LH, OP_LHU, OP_SH:       bad = lo[0];
      default:                    bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Bundle of request, response and data-memory signals for the LSU memory port.
// Latency: wires only.
// Backpressure: req_valid/req_ready on requests, resp_valid/resp_ready on responses.
interface lsu_mem_port_if #(
  parameter int AW = 16
);
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;

  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;

  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [2:0]    mem_wr;
  logic [31:0]   mem_rdata;

  // The LSU itself: takes requests, returns responses, drives the memory.
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_wr
  );

  // The pipeline stage plus memory side facing the LSU.
  modport master (
    output req_valid, req_op, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_wr
  );
endinterface

// File: rtl/lsu_extract.sv
// Big-endian lane select and sign/zero extension of a memory read word for the load ops.
// Latency: combinational.
// Backpressure: none.
module lsu_extract
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  op_e         op,
  output logic [31:0] result
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Byte at offset o sits in word[31-8o -: 8]; the half starts at the same byte.
  always_comb begin
    lane_byte = word[31:24];
    lane_half = word[31:16];
    case (offset)
      2'd1: begin
        lane_byte = word[23:16];
        lane_half = word[23:8];
      end
      2'd2: begin
        lane_byte = word[15:8];
        lane_half = word[15:0];
      end
      2'd3: begin
        // Only byte loads reach here; the half value is never selected.
        lane_byte = word[7:0];
        lane_half = word[15:0];
      end
      default: begin
        lane_byte = word[31:24];
        lane_half = word[31:16];
      end
    endcase
  end

  // Widen the selected lane according to the op; word loads pass straight through.
  always_comb begin
    result = word;
    case (op)
      OP_LB:   result = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  result = {24'd0, lane_byte};
      OP_LH:   result = {{16{lane_half[15]}}, lane_half};
      OP_LHU:  result = {16'd0, lane_half};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator to a big-endian byte memory with LL/SC reservation and alignment check.
// Latency from accept: error response +1, store/SC +2, load/LL +3 cycles; one request in flight.
// Backpressure: req_ready only in IDLE; response held until resp_ready, then IDLE next cycle.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 32
)
(
  input logic           Clk,
  input logic           Reset,
  lsu_mem_port_if.slave bus
);

  state_e        state_q;
  state_e        state_d;
  op_e           op_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          res_valid_q;
  logic [AW-3:0] res_addr_q;
  logic [DW-1:0] resp_rdata_q;
  logic          resp_err_q;

  op_e           req_op_e;
  logic          req_bad;
  logic          accept;
  logic          sc_ok;
  mw_e           mem_wr_c;
  logic [31:0]   load_result;

  assign req_op_e = op_e'(bus.req_op);
  assign req_bad  = !op_legal(bus.req_op) || op_misaligned(req_op_e, bus.req_addr[1:0]);
  assign accept   = (state_q == ST_IDLE) && bus.req_valid;
  // Reservation is compared at word granularity against the registered request.
  assign sc_ok    = res_valid_q && (res_addr_q == addr_q[AW-1:2]);

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and the memory write code; a write is only ever driven from ACCESS.
  always_comb begin
    state_d  = state_q;
    mem_wr_c = MW_READ;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_d = req_bad ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        case (op_q)
          OP_SW:   mem_wr_c = MW_WORD;
          OP_SB:   mem_wr_c = MW_BYTE;
          OP_SH:   mem_wr_c = MW_HALF;
          OP_SC:   mem_wr_c = sc_ok ? MW_SC : MW_READ;
          default: mem_wr_c = MW_READ;
        endcase
        state_d = op_is_load(op_q) ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Capture the accepted request; pipeline inputs are ignored afterwards.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      op_q   <= OP_LW;
      addr_q <= '0;
    end else if (accept) begin
      op_q   <= req_op_e;
      addr_q <= bus.req_addr;
    end
  end

  // Memory address/data registers; they hold across idle cycles and errored requests.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (accept && !req_bad) begin
      case (req_op_e)
        // The memory writes a half at Ad+2/Ad+3, so point Ad two bytes below the target.
        OP_SH:               mem_addr_q <= bus.req_addr - AW'(2);
        OP_SW, OP_SB, OP_SC: mem_addr_q <= bus.req_addr;
        default:             mem_addr_q <= {bus.req_addr[AW-1:2], 2'b00};
      endcase
      case (req_op_e)
        OP_SW, OP_SC: mem_wdata_q <= bus.req_wdata;
        OP_SB:        mem_wdata_q <= {24'd0, bus.req_wdata[7:0]};
        OP_SH:        mem_wdata_q <= {16'd0, bus.req_wdata[15:0]};
        default:      mem_wdata_q <= mem_wdata_q;
      endcase
    end
  end

  // Single LL/SC reservation; only requests that reach ACCESS can touch it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      res_valid_q <= 1'b0;
      res_addr_q  <= '0;
    end else if (state_q == ST_ACCESS) begin
      if (op_q == OP_LL) begin
        res_valid_q <= 1'b1;
        res_addr_q  <= addr_q[AW-1:2];
      end else if (op_q == OP_SC) begin
        res_valid_q <= 1'b0;
      end else if (op_is_store(op_q) && (res_addr_q == addr_q[AW-1:2])) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  lsu_extract u_extract (
    .word   (bus.mem_rdata),
    .offset (addr_q[1:0]),
    .op     (op_q),
    .result (load_result)
  );

  // Response registers: cleared on accept, then filled by SC outcome or load data.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            resp_rdata_q <= '0;
            resp_err_q   <= req_bad;
          end
        end
        ST_ACCESS: begin
          if (op_q == OP_SC) begin
            resp_rdata_q <= DW'(sc_ok);
          end
        end
        ST_WAIT: begin
          resp_rdata_q <= load_result;
        end
        default: begin
          resp_rdata_q <= resp_rdata_q;
        end
      endcase
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_wr     = mem_wr_c;

endmodule
